id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage pipelined MIPS core. It sits directly upstream of the 32-bit ALU and drives its BussA, BussB and ALUControl inputs. It captures decoded operands and control each cycle, and applies EX/MEM and MEM/WB operand forwarding. It also detects load-use hazards and inserts bubbles on stall or flush.

Parameters:
DATA_W, 32, operand/result width (ALU is fixed 32; other values unsupported)
REG_ADDR_W, 5, register specifier width

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_rs, id_rt, id_rd  in  REG_ADDR_W each  source/dest specifiers (id_rd already muxed rt/rd by decode)
id_uses_rt  in  1  instruction reads rt as a source
id_rs_data, id_rt_data  in  DATA_W each  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_alu_src  in  1  0: B=rt, 1: B=imm
id_alu_control  in  2  ALU op code
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  downstream control
stall_in  in  1  hold stage contents (downstream stall)
flush_in  in  1  squash instruction entering EX (branch/jump)
exm_reg_write  in  1  EX/MEM writes a register
exm_rd  in  REG_ADDR_W  EX/MEM destination
exm_result  in  DATA_W  EX/MEM ALU result
wb_reg_write  in  1  MEM/WB writes a register
wb_rd  in  REG_ADDR_W  MEM/WB destination
wb_result  in  DATA_W  MEM/WB write-back data
bus_a, bus_b  out  DATA_W each  ALU operands (to BussA/BussB)
alu_control  out  2  to ALUControl
ex_valid  out  1  EX slot holds a real instruction
ex_rd  out  REG_ADDR_W  registered destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control
ex_store_data  out  DATA_W  forwarded rt value for stores
load_use_stall  out  1  request to freeze PC and IF/ID

Behaviour:
- Reset (async, immediate): all registered fields = 0, including ex_valid and control bits. Outputs then read bus_a = bus_b = 0, alu_control = 00 and load_use_stall = 0.
- Update priority per rising edge: reset > flush_in > stall_in > load_use_stall > normal load.
  - flush_in: capture a bubble.
  - stall_in: hold every field.
  - load_use_stall: capture a bubble; upstream holds the instruction.
  - normal load: capture all id_* fields; ex_valid = id_valid.
- Bubble definition: ex_valid = 0 and reg_write/mem_read/mem_write/mem_to_reg = 0. The alu_control and data fields are zeroed.
- Latency: one cycle from id_* to registered fields. Forwarding and the bus outputs are combinational from the registered fields and the exm_*/wb_* inputs.
- Forwarding for source A (rs); B (rt) uses the same rule:
  - If exm_reg_write and exm_rd != 0 and exm_rd == rs, use exm_result.
  - Else if wb_reg_write and wb_rd != 0 and wb_rd == rs, use wb_result.
  - Else use the registered read data.
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- bus_b = imm if the registered alu_src = 1, else the forwarded rt.
- ex_store_data = forwarded rt, regardless of alu_src.
- During a hold, forwarding is re-evaluated every cycle from the held fields.
- load_use_stall is combinational and asserts when all hold:
  - ex_valid, ex_mem_read, ex_rd != 0, id_valid;
  - ex_rd == id_rs, or (id_uses_rt and ex_rd == id_rt).
  - It is masked to 0 while flush_in = 1.
- Stall behaviour: a load-use stall lasts exactly one cycle, because the next cycle's EX slot is a bubble.
- Reset mid-stall: clears everything and drops load_use_stall at once.
- No arithmetic is performed here; widths pass through unchanged.

Decomposition:
- mips_pkg:
  - ALU op constants: ALU_ADD = 2'b00, ALU_XOR = 2'b01, ALU_SUB = 2'b10, ALU_SLT = 2'b11.
  - DATA_W and REG_ADDR_W defaults.
  - A packed struct id_ex_ctrl_t holding reg_write, mem_read, mem_write, mem_to_reg, alu_src and alu_control.
- One sub-module fwd_unit: the pure combinational 3:1 forwarding select for one operand. It is instantiated twice, for rs and for rt.

Test Plan:
- Reset then load id_rs_data = 0x0000_0005, id_rt_data = 0x0000_0003, alu_control = 2'b10, with no forwarding. After one edge: bus_a = 5, bus_b = 3, alu_control = 2'b10, ex_valid = 1.
- EX/MEM forward: registered rs = 8, exm_reg_write = 1, exm_rd = 8, exm_result = 0xDEAD_BEEF, with wb also matching at 0x1111_1111. Expect bus_a = 0xDEAD_BEEF.
- Register 0 and source B: exm_rd = 0 with exm_reg_write = 1 and rs = 0 → bus_a = registered data. Separately, alu_src = 1 with imm = 0xFFFF_FFFC → bus_b = 0xFFFF_FFFC while ex_store_data = the forwarded rt.
- Load-use: EX holds lw with rd = 4; ID holds add with rs = 4. Expect load_use_stall = 1 for exactly one cycle. The next EX slot is a bubble (ex_valid = 0, all control 0), then the add enters with wb forwarding.
- Flush over stall: assert flush_in and stall_in in the same cycle. Expect a bubble captured and load_use_stall = 0. Then stall_in alone holds bus_a/bus_b steady across 3 cycles.
- Async reset mid-operation: assert reset between clock edges. Expect all outputs 0 before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline.
// Imported by every stage and by the forwarding helpers.
package mips_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_control;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_NOP = '{
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    mem_to_reg:  1'b0,
    alu_src:     1'b0,
    alu_control: ALU_ADD
  };

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register.
// EX/MEM beats MEM/WB; register 0 is never forwarded.
module fwd_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]     exm_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_result,
  output logic [DATA_W-1:0]     data
);

  logic exm_hit;
  logic wb_hit;
  logic wb_sel;

  assign exm_hit = exm_reg_write
                && (exm_rd != '0)
                && (exm_rd == src);

  assign wb_hit = wb_reg_write
               && (wb_rd != '0)
               && (wb_rd == src);

  // wb only selected when the younger result misses
  assign wb_sel = wb_hit && !exm_hit;

  always_comb begin
    data = reg_data;
    unique case (1'b1)
      exm_hit: data = exm_result;
      wb_sel:  data = wb_result;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use hazard detection and bubble insertion.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rt,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_alu_src,
  input  logic [1:0]            id_alu_control,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]     exm_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_result,
  output logic [DATA_W-1:0]     bus_a,
  output logic [DATA_W-1:0]     bus_b,
  output logic [1:0]            alu_control,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic                  load_use_stall
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    id_ex_ctrl_t           ctrl;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;
  id_ex_t id_pkt;

  logic              rs_hit;
  logic              rt_hit;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  always_comb begin
    id_pkt.valid            = id_valid;
    id_pkt.rs               = id_rs;
    id_pkt.rt               = id_rt;
    id_pkt.rd               = id_rd;
    id_pkt.rs_data          = id_rs_data;
    id_pkt.rt_data          = id_rt_data;
    id_pkt.imm              = id_imm;
    id_pkt.ctrl.reg_write   = id_reg_write;
    id_pkt.ctrl.mem_read    = id_mem_read;
    id_pkt.ctrl.mem_write   = id_mem_write;
    id_pkt.ctrl.mem_to_reg  = id_mem_to_reg;
    id_pkt.ctrl.alu_src     = id_alu_src;
    id_pkt.ctrl.alu_control = id_alu_control;
  end

  // Load in EX whose destination the decoding instruction reads
  assign rs_hit = (ex_q.rd == id_rs);
  assign rt_hit = id_uses_rt && (ex_q.rd == id_rt);

  assign load_use_stall = !flush_in
                       && ex_q.valid
                       && ex_q.ctrl.mem_read
                       && (ex_q.rd != '0)
                       && id_valid
                       && (rs_hit || rt_hit);

  always_comb begin
    ex_d = ex_q;
    if (flush_in) begin
      ex_d      = '0;
      ex_d.ctrl = CTRL_NOP;
    end else if (stall_in) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d      = '0;
      ex_d.ctrl = CTRL_NOP;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_unit #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .src           (ex_q.rs),
    .reg_data      (ex_q.rs_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .data          (fwd_a)
  );

  fwd_unit #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .src           (ex_q.rt),
    .reg_data      (ex_q.rt_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .data          (fwd_b)
  );

  assign bus_a         = fwd_a;
  assign bus_b         = ex_q.ctrl.alu_src ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_control   = ex_q.ctrl.alu_control;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.ctrl.reg_write;
  assign ex_mem_read   = ex_q.ctrl.mem_read;
  assign ex_mem_write  = ex_q.ctrl.mem_write;
  assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, directed hazard
// sequences and a randomized run against a reference model.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src;
  logic [1:0]  id_alu_control;
  logic        id_reg_write, id_mem_read;
  logic        id_mem_write, id_mem_to_reg;
  logic        stall_in, flush_in;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [31:0] bus_a, bus_b, ex_store_data;
  logic [1:0]  alu_control;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic        ex_mem_write, ex_mem_to_reg;
  logic        load_use_stall;

  id_ex_stage dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_uses_rt     (id_uses_rt),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_alu_src     (id_alu_src),
    .id_alu_control (id_alu_control),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .id_mem_to_reg  (id_mem_to_reg),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .exm_reg_write  (exm_reg_write),
    .exm_rd         (exm_rd),
    .exm_result     (exm_result),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result),
    .bus_a          (bus_a),
    .bus_b          (bus_b),
    .alu_control    (alu_control),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_store_data  (ex_store_data),
    .load_use_stall (load_use_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents of the EX slot as an instruction record
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        rw, mr, mw, m2r, src;
    logic [1:0]  alu;
  } slot_t;

  slot_t m;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd_ref(input logic [4:0] r,
                                          input logic [31:0] v);
    if (r == 0) return v;
    if (exm_reg_write && exm_rd == r) return exm_result;
    if (wb_reg_write && wb_rd == r) return wb_result;
    return v;
  endfunction

  function automatic logic lus_ref();
    logic reads;
    reads = (m.rd == id_rs) || (id_uses_rt && m.rd == id_rt);
    return !flush_in && m.valid && m.mr && m.rd != 0
           && id_valid && reads;
  endfunction

  task automatic model_clear();
    m = '{valid: 0, rs: 0, rt: 0, rd: 0, rsd: 0, rtd: 0, imm: 0,
          rw: 0, mr: 0, mw: 0, m2r: 0, src: 0, alu: 0};
  endtask

  task automatic model_edge();
    if (flush_in || (!stall_in && lus_ref())) begin
      model_clear();
    end else if (!stall_in) begin
      m = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
            rsd: id_rs_data, rtd: id_rt_data, imm: id_imm,
            rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
            m2r: id_mem_to_reg, src: id_alu_src, alu: id_alu_control};
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] eb;
    eb = m.src ? m.imm : fwd_ref(m.rt, m.rtd);
    chk({tag, ".bus_a"}, bus_a, fwd_ref(m.rs, m.rsd));
    chk({tag, ".bus_b"}, bus_b, eb);
    chk({tag, ".store"}, ex_store_data, fwd_ref(m.rt, m.rtd));
    chk({tag, ".alu"}, 32'(alu_control), 32'(m.alu));
    chk({tag, ".valid_rd"}, {ex_valid, ex_rd}, {m.valid, m.rd});
    chk({tag, ".ctrl"},
        {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
        {m.rw, m.mr, m.mw, m.m2r});
    chk({tag, ".lus"}, 32'(load_use_stall), 32'(lus_ref()));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_src = 0;
    id_alu_control = ALU_ADD; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0;
    stall_in = 0; flush_in = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic mr,
                        input logic ut);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_uses_rt = ut;
    id_mem_read = mr; id_reg_write = 1; id_mem_to_reg = mr;
    id_alu_src = 0; id_alu_control = ALU_ADD;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".bus_a"}, bus_a, 32'h0);
    chk({tag, ".bus_b"}, bus_b, 32'h0);
    chk({tag, ".alu"}, 32'(alu_control), 32'h0);
    chk({tag, ".valid"}, 32'(ex_valid), 32'h0);
    chk({tag, ".ctrl"},
        {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 4'h0);
    chk({tag, ".lus"}, 32'(load_use_stall), 32'h0);
  endtask

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic        src;
    logic [1:0]  alu;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbres;
    logic [31:0] ea, eb, est;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{rs: 1, rt: 2, rsd: 5, rtd: 3, imm: 0, src: 0, alu: ALU_SUB, exw: 0, exrd: 0, exres: 0, wbw: 0, wbrd: 0, wbres: 0, ea: 5, eb: 3, est: 3};
    vecs[1] = '{rs: 8, rt: 9, rsd: 1, rtd: 32'h22, imm: 0, src: 0, alu: ALU_ADD, exw: 1, exrd: 8, exres: 32'hDEADBEEF, wbw: 1, wbrd: 8, wbres: 32'h11111111, ea: 32'hDEADBEEF, eb: 32'h22, est: 32'h22};
    vecs[2] = '{rs: 0, rt: 0, rsd: 32'h77, rtd: 32'h66, imm: 0, src: 0, alu: ALU_XOR, exw: 1, exrd: 0, exres: 32'hAAAA, wbw: 1, wbrd: 0, wbres: 32'hBBBB, ea: 32'h77, eb: 32'h66, est: 32'h66};
    vecs[3] = '{rs: 1, rt: 3, rsd: 32'h40, rtd: 32'h9, imm: 32'hFFFFFFFC, src: 1, alu: ALU_ADD, exw: 0, exrd: 3, exres: 32'h5, wbw: 1, wbrd: 3, wbres: 32'h1234, ea: 32'h40, eb: 32'hFFFFFFFC, est: 32'h1234};
    vecs[4] = '{rs: 7, rt: 2, rsd: 32'h1, rtd: 32'h2, imm: 0, src: 0, alu: ALU_SLT, exw: 0, exrd: 7, exres: 32'h99, wbw: 1, wbrd: 7, wbres: 32'h55, ea: 32'h55, eb: 32'h2, est: 32'h2};
    vecs[5] = '{rs: 6, rt: 6, rsd: 32'h1, rtd: 32'h2, imm: 0, src: 0, alu: ALU_SUB, exw: 1, exrd: 6, exres: 32'hF00D, wbw: 1, wbrd: 5, wbres: 32'h3, ea: 32'hF00D, eb: 32'hF00D, est: 32'hF00D};

    set_idle();
    model_clear();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    check_zero("reset");

    // Forwarding and operand selection table
    foreach (vecs[i]) begin
      set_idle();
      set_id(vecs[i].rs, vecs[i].rt, 5'd10, vecs[i].rsd,
             vecs[i].rtd, 1'b0, 1'b1);
      id_imm = vecs[i].imm;
      id_alu_src = vecs[i].src;
      id_alu_control = vecs[i].alu;
      tick();
      exm_reg_write = vecs[i].exw;
      exm_rd = vecs[i].exrd;
      exm_result = vecs[i].exres;
      wb_reg_write = vecs[i].wbw;
      wb_rd = vecs[i].wbrd;
      wb_result = vecs[i].wbres;
      #1;
      chk($sformatf("vec%0d.bus_a", i), bus_a, vecs[i].ea);
      chk($sformatf("vec%0d.bus_b", i), bus_b, vecs[i].eb);
      chk($sformatf("vec%0d.store", i), ex_store_data, vecs[i].est);
      chk($sformatf("vec%0d.alu", i), 32'(alu_control),
          32'(vecs[i].alu));
      chk($sformatf("vec%0d.valid", i), 32'(ex_valid), 32'h1);
    end

    // Load-use: lw r4 then add reading r4
    set_idle();
    set_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 1'b1, 1'b0);
    tick();
    set_id(5'd4, 5'd5, 5'd6, 32'h0, 32'h10, 1'b0, 1'b1);
    #1;
    chk("lu.stall_on", 32'(load_use_stall), 32'h1);
    tick();
    chk("lu.bubble_valid", 32'(ex_valid), 32'h0);
    chk("lu.bubble_ctrl",
        {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 4'h0);
    chk("lu.stall_off", 32'(load_use_stall), 32'h0);
    wb_reg_write = 1; wb_rd = 4; wb_result = 32'hCAFE0000;
    tick();
    chk("lu.add_valid", 32'(ex_valid), 32'h1);
    chk("lu.add_bus_a", bus_a, 32'hCAFE0000);
    chk("lu.add_bus_b", bus_b, 32'h10);
    chk("lu.add_rd", 32'(ex_rd), 32'd6);

    // Flush beats stall and masks the hazard
    set_idle();
    set_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 1'b1, 1'b0);
    tick();
    set_id(5'd4, 5'd5, 5'd6, 32'h0, 32'h10, 1'b0, 1'b1);
    flush_in = 1; stall_in = 1;
    #1;
    chk("fl.lus_masked", 32'(load_use_stall), 32'h0);
    tick();
    chk("fl.bubble_valid", 32'(ex_valid), 32'h0);
    chk("fl.bubble_ctrl",
        {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 4'h0);
    set_idle();
    set_id(5'd2, 5'd3, 5'd7, 32'h100, 32'h200, 1'b0, 1'b1);
    tick();
    stall_in = 1;
    set_id(5'd9, 5'd9, 5'd9, 32'h333, 32'h444, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d.bus_a", c), bus_a, 32'h100);
      chk($sformatf("hold%0d.bus_b", c), bus_b, 32'h200);
    end
    exm_reg_write = 1; exm_rd = 2; exm_result = 32'hABC;
    #1;
    chk("hold.refwd", bus_a, 32'hABC);

    // Async reset between edges drops everything at once
    set_idle();
    set_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 1'b1, 1'b0);
    tick();
    set_id(5'd4, 5'd5, 5'd6, 32'h55, 32'h10, 1'b0, 1'b1);
    #1;
    chk("ar.lus_before", 32'(load_use_stall), 32'h1);
    #1;
    reset = 1;
    #1;
    check_zero("ar");
    model_clear();
    #1;
    reset = 0;
    set_idle();
    tick();

    // Randomized run against the model
    for (int c = 0; c < 400; c++) begin
      id_valid = ($urandom_range(0, 9) < 8);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_imm = $urandom;
      id_alu_src = 1'($urandom);
      id_alu_control = 2'($urandom);
      id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(0, 9) < 3);
      id_mem_write = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      flush_in = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 19) < 3);
      exm_reg_write = 1'($urandom);
      exm_rd = 5'($urandom_range(0, 3));
      exm_result = $urandom;
      wb_reg_write = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3));
      wb_result = $urandom;
      #1;
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
